// File: rtl/secure_boot_pkg.sv
// rtl/secure_boot_pkg.sv - shared types, constants and helpers for the secure memory gate
package secure_boot_pkg;

    localparam int TOKEN_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    // Region index is the top reg_w bits of a word address of width addr_w
    function automatic logic [31:0] region_idx(
        input logic [31:0] addr,
        input int          addr_w,
        input int          reg_w
    );
        logic [31:0] v_shifted;
        v_shifted = addr >> (addr_w - reg_w);
        return v_shifted;
    endfunction

endpackage

// File: rtl/gate_ram.sv
// rtl/gate_ram.sv - single-port synchronous RAM with registered read-before-write output
module gate_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read samples the old word, so a same-cycle write is seen only by later reads
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/secure_mem_gate.sv
// rtl/secure_mem_gate.sv - token-authenticated, time-limited per-region access gate to an internal RAM
module secure_mem_gate
    import secure_boot_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 8,
    parameter int NUM_REGIONS    = 4,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 256,
    parameter int SESSION_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           auth_req,
    input  logic [TOKEN_W-1:0]             auth_token,
    input  logic [TOKEN_W-1:0]             auth_ref,
    input  logic [$clog2(NUM_REGIONS)-1:0] auth_region,
    input  logic                           revoke,
    output logic                           auth_done,
    output logic                           auth_ok,
    output logic                           locked,
    output logic [NUM_REGIONS-1:0]         grant,
    input  logic                           we,
    input  logic                           re,
    input  logic [ADDR_W-1:0]              addr,
    input  logic [DATA_W-1:0]              din,
    output logic [DATA_W-1:0]              dout,
    output logic                           rvalid,
    output logic                           err
);

    localparam int REG_W  = $clog2(NUM_REGIONS);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int SES_W  = $clog2(SESSION_CYCLES + 1);
    localparam int LCK_W  = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);
    localparam logic [SES_W-1:0]  SES_LOAD = SES_W'(SESSION_CYCLES);
    localparam logic [LCK_W-1:0]  LCK_LOAD = LCK_W'(LOCKOUT_CYCLES);

    state_t                 r_state;
    logic [TOKEN_W-1:0]     r_token;
    logic [TOKEN_W-1:0]     r_ref;
    logic [REG_W-1:0]       r_region;
    logic [FAIL_W-1:0]      r_fail_cnt;
    logic [SES_W-1:0]       r_ses_cnt;
    logic [LCK_W-1:0]       r_lck_cnt;
    logic [NUM_REGIONS-1:0] r_grant;
    logic                   r_auth_done;
    logic                   r_auth_ok;
    logic                   r_locked;
    logic                   r_rvalid;
    logic                   r_err;
    logic                   r_rd_ok;

    logic                   w_match;
    logic [FAIL_W-1:0]      w_fail_next;
    logic [NUM_REGIONS-1:0] w_region_bit;
    logic [REG_W-1:0]       w_addr_region;
    logic                   w_acc_granted;
    logic                   w_ram_we;
    logic                   w_ram_re;
    logic [DATA_W-1:0]      w_ram_rdata;

    assign w_match       = (r_token == r_ref);
    assign w_fail_next   = (r_fail_cnt >= FAIL_MAX) ? FAIL_MAX : r_fail_cnt + 1'b1;
    assign w_region_bit  = NUM_REGIONS'(1) << r_region;
    assign w_addr_region = REG_W'(region_idx(32'(addr), ADDR_W, REG_W));
    assign w_acc_granted = r_grant[w_addr_region];
    assign w_ram_we      = we && w_acc_granted;
    assign w_ram_re      = re && w_acc_granted;

    // Authentication FSM with session timer, fail counter, lockout timer and grant bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_token     <= '0;
            r_ref       <= '0;
            r_region    <= '0;
            r_fail_cnt  <= '0;
            r_ses_cnt   <= '0;
            r_lck_cnt   <= '0;
            r_grant     <= '0;
            r_auth_done <= 1'b0;
            r_auth_ok   <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_auth_done <= 1'b0;
            r_auth_ok   <= 1'b0;

            // Session runs down to zero; grants vanish on the last tick
            if (r_ses_cnt != '0) begin
                r_ses_cnt <= r_ses_cnt - 1'b1;
            end
            if (r_ses_cnt == SES_W'(1)) begin
                r_grant <= '0;
            end

            case (r_state)
                IDLE: begin
                    if (auth_req) begin
                        r_token  <= auth_token;
                        r_ref    <= auth_ref;
                        r_region <= auth_region;
                        r_state  <= CHECK;
                    end
                end
                CHECK: begin
                    r_auth_done <= 1'b1;
                    if (w_match) begin
                        // A success overrides a coincident session expiry
                        r_auth_ok  <= 1'b1;
                        r_grant    <= r_grant | w_region_bit;
                        r_ses_cnt  <= SES_LOAD;
                        r_fail_cnt <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_fail_cnt <= w_fail_next;
                        if (w_fail_next == FAIL_MAX) begin
                            r_grant   <= '0;
                            r_lck_cnt <= LCK_LOAD;
                            r_locked  <= 1'b1;
                            r_state   <= LOCKOUT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                LOCKOUT: begin
                    r_grant <= '0;
                    if (r_lck_cnt <= LCK_W'(1)) begin
                        r_lck_cnt  <= '0;
                        r_fail_cnt <= '0;
                        r_locked   <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_lck_cnt <= r_lck_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Revoke beats every grant source, but leaves fail count and lockout alone
            if (revoke) begin
                r_grant <= '0;
            end
        end
    end

    // Access filter: response flags one cycle after the request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rd_ok  <= 1'b0;
        end else begin
            r_rvalid <= re;
            r_err    <= (we || re) && !w_acc_granted;
            r_rd_ok  <= w_ram_re;
        end
    end

    gate_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (addr),
        .i_wdata (din),
        .o_rdata (w_ram_rdata)
    );

    assign auth_done = r_auth_done;
    assign auth_ok   = r_auth_ok;
    assign locked    = r_locked;
    assign grant     = r_grant;
    assign rvalid    = r_rvalid;
    assign err       = r_err;
    // Denied reads and idle cycles present zero rather than stale RAM output
    assign dout      = r_rd_ok ? w_ram_rdata : '0;

endmodule

// File: tb/tb_secure_mem_gate.sv
// tb/tb_secure_mem_gate.sv - scoreboard bench for secure_mem_gate
module tb_secure_mem_gate;

    localparam logic [127:0] REF = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BAD = 128'h00112233445566778899aabbccddeefe;

    logic         clk = 1'b0;
    logic         rst;
    logic         auth_req;
    logic [127:0] auth_token;
    logic [127:0] auth_ref;
    logic [1:0]   auth_region;
    logic         revoke;
    logic         auth_done;
    logic         auth_ok;
    logic         locked;
    logic [3:0]   grant;
    logic         we;
    logic         re;
    logic [11:0]  addr;
    logic [7:0]   din;
    logic [7:0]   dout;
    logic         rvalid;
    logic         err;

    typedef struct packed {
        logic       rvalid;
        logic       err;
        logic [7:0] dout;
    } acc_t;

    acc_t       acc_q[$];
    logic       auth_q[$];
    acc_t       mon_e;
    logic [7:0] m_mem [int];
    logic [3:0] m_grant;
    int         n_checks = 0;
    int         n_errors = 0;
    int         k;

    secure_mem_gate #(
        .ADDR_W         (12),
        .DATA_W         (8),
        .NUM_REGIONS    (4),
        .MAX_FAIL       (3),
        .LOCKOUT_CYCLES (256),
        .SESSION_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .auth_req    (auth_req),
        .auth_token  (auth_token),
        .auth_ref    (auth_ref),
        .auth_region (auth_region),
        .revoke      (revoke),
        .auth_done   (auth_done),
        .auth_ok     (auth_ok),
        .locked      (locked),
        .grant       (grant),
        .we          (we),
        .re          (re),
        .addr        (addr),
        .din         (din),
        .dout        (dout),
        .rvalid      (rvalid),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic tb_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_auth(input logic [127:0] tok, input logic [1:0] rg,
                              input logic exp_ok, input logic revoke_in_check);
        auth_req    = 1'b1;
        auth_token  = tok;
        auth_region = rg;
        auth_q.push_back(exp_ok);
        step();
        auth_req = 1'b0;
        revoke   = revoke_in_check;
        tb_check("auth_busy", 32'(auth_done), 32'd0);
        step();
        revoke = 1'b0;
        tb_check("auth_lat", 32'(auth_done), 32'd1);
    endtask

    task automatic access(input logic w, input logic r, input logic [11:0] a, input logic [7:0] d);
        logic       granted;
        logic [1:0] rg;
        rg      = a[11:10];
        granted = m_grant[rg];
        we = w; re = r; addr = a; din = d;
        if (granted) begin
            if (r) acc_q.push_back({1'b1, 1'b0, m_mem[int'(a)]});
            if (w) m_mem[int'(a)] = d;
        end else begin
            acc_q.push_back({r, 1'b1, 8'h00});
        end
        step();
        we = 1'b0;
        re = 1'b0;
        @(negedge clk);
        #1;
        tb_check("acc_resp", 32'(acc_q.size()), 32'd0);
    endtask

    // Monitor: pop expectations when the DUT responds
    always @(negedge clk) begin
        if (!rst) begin
            if (auth_done) begin
                if (auth_q.size() == 0) tb_check("auth_unexp", 32'd1, 32'd0);
                else tb_check("auth_ok", 32'(auth_ok), 32'(auth_q.pop_front()));
            end
            if (rvalid || err) begin
                if (acc_q.size() == 0) begin
                    tb_check("acc_unexp", 32'({rvalid, err}), 32'd0);
                end else begin
                    mon_e = acc_q.pop_front();
                    tb_check("rvalid", 32'(rvalid), 32'(mon_e.rvalid));
                    tb_check("err", 32'(err), 32'(mon_e.err));
                    tb_check("dout", 32'(dout), 32'(mon_e.dout));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; auth_req = 1'b0; auth_token = '0; auth_ref = REF; auth_region = '0;
        revoke = 1'b0; we = 1'b0; re = 1'b0; addr = '0; din = '0; m_grant = '0;
        repeat (2) step();
        tb_check("rst_auth_done", 32'(auth_done), 32'd0);
        tb_check("rst_auth_ok", 32'(auth_ok), 32'd0);
        tb_check("rst_locked", 32'(locked), 32'd0);
        tb_check("rst_grant", 32'(grant), 32'd0);
        tb_check("rst_dout", 32'(dout), 32'd0);
        tb_check("rst_rvalid", 32'(rvalid), 32'd0);
        tb_check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        step();

        // Region 1 grant, write and read back
        start_auth(REF, 2'd1, 1'b1, 1'b0);
        tb_check("grant_r1", 32'(grant), 32'h2);
        m_grant[1] = 1'b1;
        access(1'b1, 1'b0, 12'h440, 8'hA5);
        access(1'b0, 1'b1, 12'h440, 8'h00);

        // Region 0: seed data, read-before-write, then denied accesses after revoke
        start_auth(REF, 2'd0, 1'b1, 1'b0);
        m_grant[0] = 1'b1;
        access(1'b1, 1'b0, 12'h040, 8'h3C);
        access(1'b1, 1'b0, 12'h041, 8'h11);
        access(1'b1, 1'b1, 12'h041, 8'h22);
        access(1'b0, 1'b1, 12'h041, 8'h00);
        revoke = 1'b1;
        step();
        revoke  = 1'b0;
        m_grant = '0;
        tb_check("grant_revoke", 32'(grant), 32'd0);
        access(1'b1, 1'b0, 12'h040, 8'h77);
        access(1'b0, 1'b1, 12'h040, 8'h00);
        start_auth(REF, 2'd0, 1'b1, 1'b0);
        m_grant[0] = 1'b1;
        access(1'b0, 1'b1, 12'h040, 8'h00);

        // Session expiry for region 2
        start_auth(REF, 2'd2, 1'b1, 1'b0);
        m_grant[2] = 1'b1;
        k = 0;
        while (grant[2] === 1'b1 && k < 40) begin
            step();
            k++;
        end
        tb_check("session_len", 32'(k), 32'd16);
        tb_check("grant_expired", 32'(grant), 32'd0);
        m_grant = '0;
        access(1'b1, 1'b0, 12'h880, 8'h5A);

        // Three failures -> lockout; requests ignored while locked
        start_auth(BAD, 2'd3, 1'b0, 1'b0);
        start_auth(BAD, 2'd3, 1'b0, 1'b0);
        start_auth(BAD, 2'd3, 1'b0, 1'b0);
        k = 0;
        while (locked === 1'b1 && k < 300) begin
            auth_req   = (k == 10);
            auth_token = REF;
            if (k == 5) tb_check("lock_grant", 32'(grant), 32'd0);
            step();
            k++;
        end
        auth_req = 1'b0;
        tb_check("lock_len", 32'(k), 32'd256);
        tb_check("lock_clear", 32'(locked), 32'd0);
        step();
        start_auth(REF, 2'd3, 1'b1, 1'b0);
        tb_check("grant_after_lock", 32'(grant), 32'h8);

        // A success clears the fail count
        start_auth(BAD, 2'd0, 1'b0, 1'b0);
        start_auth(BAD, 2'd0, 1'b0, 1'b0);
        start_auth(REF, 2'd1, 1'b1, 1'b0);
        start_auth(BAD, 2'd0, 1'b0, 1'b0);
        start_auth(BAD, 2'd0, 1'b0, 1'b0);
        tb_check("no_lock", 32'(locked), 32'd0);
        start_auth(BAD, 2'd0, 1'b0, 1'b0);
        tb_check("lock_again", 32'(locked), 32'd1);

        // Reset mid-lockout
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tb_check("rst_mid_locked", 32'(locked), 32'd0);
        tb_check("rst_mid_grant", 32'(grant), 32'd0);
        start_auth(REF, 2'd2, 1'b1, 1'b0);
        tb_check("grant_after_rst", 32'(grant), 32'h4);

        // Revoke coincident with a successful check
        start_auth(REF, 2'd1, 1'b1, 1'b1);
        tb_check("revoke_wins", 32'(grant), 32'd0);

        repeat (2) step();
        tb_check("auth_q_empty", 32'(auth_q.size()), 32'd0);
        tb_check("acc_q_empty", 32'(acc_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/secure_mem_gate.md
# secure_mem_gate

Parametrised successor to the single-region secure memory access controller. It authenticates by comparing a decrypted 128-bit token from the AES decrypt path against a reference plaintext, then grants time-limited write/read access to one of NUM_REGIONS address regions of an internal RAM. It adds a session timeout, a failed-attempt counter and a timed lockout. It sits between the AES-128 decrypt core and the boot-image memory.

## Interface
Clock `clk`; reset `rst`, synchronous, active-high.

Parameters:
- ADDR_W, 12, word address width; RAM depth is 2**ADDR_W.
- DATA_W, 8, RAM word width.
- NUM_REGIONS, 4, power of two; the region is addr[ADDR_W-1 -: log2(NUM_REGIONS)].
- MAX_FAIL, 3, consecutive failed authentications before lockout (≥1).
- LOCKOUT_CYCLES, 256, lockout duration in clk cycles (≥1).
- SESSION_CYCLES, 1024, grant lifetime in cycles after the last successful authentication (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- auth_req  in  1  one-cycle request to authenticate; sampled only in IDLE.
- auth_token  in  128  decrypted token from the AES decrypt core.
- auth_ref  in  128  expected plaintext.
- auth_region  in  log2(NUM_REGIONS)  region to unlock.
- revoke  in  1  clears all grants immediately.
- auth_done  out  1  one-cycle pulse when a check completes.
- auth_ok  out  1  result, valid with auth_done.
- locked  out  1  high while in LOCKOUT.
- grant  out  NUM_REGIONS  per-region access-granted bits.
- we  in  1  write enable.
- re  in  1  read enable.
- addr  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- dout  out  DATA_W  read data, registered.
- rvalid  out  1  read data valid.
- err  out  1  one-cycle pulse for a denied access.

## Operation
- FSM states: IDLE, CHECK, LOCKOUT.
- IDLE with auth_req: latch token, ref and region, then go to CHECK. auth_req is ignored in CHECK and LOCKOUT.
- CHECK (one cycle) on match:
  - set grant[region].
  - reload the session timer to SESSION_CYCLES.
  - clear fail_cnt.
  - pulse auth_done with auth_ok=1.
  - return to IDLE.
- CHECK on mismatch:
  - fail_cnt+1, and pulse auth_done with auth_ok=0.
  - If the new fail_cnt equals MAX_FAIL: clear all grants, load the lockout counter with LOCKOUT_CYCLES and go to LOCKOUT.
  - Otherwise return to IDLE.
- LOCKOUT:
  - locked=1, all grants forced to 0, counter decrements each cycle.
  - When the counter reaches 0: fail_cnt=0, go to IDLE.
- Session timer: decrements while nonzero. On the 1→0 transition all grants clear.
- Memory access:
  - A write takes effect when we && grant[region(addr)].
  - A read (re && grant) returns mem[addr] on the next cycle with rvalid=1.
  - we and re asserted together: the write commits and the read returns the old data.
- Denied access: we or re to an ungranted region pulses err next cycle; the write is dropped, and a read gives rvalid=1 with dout=0.
- Memory accesses in CHECK or IDLE use the current grants.

## Timing
- Reset values:
  - state=IDLE.
  - grant=0, fail_cnt=0, timers=0.
  - auth_done=0, auth_ok=0, locked=0.
  - dout=0, rvalid=0, err=0.
  - RAM contents are not reset.
- Authentication latency: auth_req in cycle N gives auth_done in N+2. grant is visible in N+2, so the first granted access can be sampled in N+2.
- Read latency: 1 cycle.
- Simultaneous events:
  - A success in CHECK in the same cycle as timer expiry: the grant is set and the timer reloads (success wins).
  - revoke in the same cycle as a success: revoke wins, grants=0, but auth_ok is still reported as 1.
  - revoke does not affect fail_cnt or LOCKOUT.
- rst asserted mid-CHECK or mid-LOCKOUT returns everything to reset values on the next edge.
- Counters saturate: fail_cnt never exceeds MAX_FAIL, and timers never wrap below 0.

## Structure
- Package `secure_boot_pkg`: FSM state enum (IDLE, CHECK, LOCKOUT), the 128-bit token width constant, and a region-index function.
- Sub-module `gate_ram`: single-port synchronous RAM (DEPTH=2**ADDR_W, DATA_W) with registered read and read-before-write behaviour.
- The top level contains the FSM, timers, grant logic and the access filter.

## Test plan
- Matching token (ref=00112233445566778899aabbccddeeff) for region 1 → auth_done with auth_ok=1 at N+2 and grant=4'b0010. Write A5 to 0x440, read it back → dout=A5, rvalid=1.
- Write to 0x040 (region 0, not granted) → err pulse, and a later read after granting region 0 returns the old contents.
- Three mismatching tokens (MAX_FAIL=3) → third auth_done has auth_ok=0, locked=1 for exactly 256 cycles, and auth_req is ignored meanwhile. After that, locked=0 and a matching token succeeds.
- Grant region 2 with SESSION_CYCLES=16 → grant[2] drops exactly 16 cycles after auth_done, and the next write to 0x880 gives err.
- Two failures then a success → fail_cnt clears. Three more failures are needed for lockout.
- revoke asserted in the same cycle as a successful CHECK → auth_ok=1 and grant=0. rst asserted mid-LOCKOUT → locked=0 and state=IDLE on the next cycle.
